// File: rtl/alu_shift_sequencer_if.sv
// alu_shift_sequencer_if: request/response bundle between control and the shift sequencer
interface alu_shift_sequencer_if #(
    parameter int WIDTH      = 32,
    parameter int COUNT_BITS = 5
);
    logic                  start;
    logic [3:0]            op;
    logic [WIDTH-1:0]      operand_a;
    logic [WIDTH-1:0]      operand_b;
    logic [COUNT_BITS-1:0] count;
    logic                  carry_in;
    logic                  busy;
    logic                  done;
    logic [WIDTH-1:0]      result;
    logic                  carry_out;
    logic                  zero_out;
    logic                  neg_out;
    logic                  over_out;
    modport master (
        output start, op, operand_a, operand_b, count, carry_in,
        input  busy, done, result, carry_out, zero_out, neg_out, over_out
    );
    modport slave (
        input  start, op, operand_a, operand_b, count, carry_in,
        output busy, done, result, carry_out, zero_out, neg_out, over_out
    );
endinterface

// File: rtl/alu_shift_sequencer.sv
// alu_shift_sequencer: repeats the ALU's 1-bit shift ops to build N-bit shifts; other ops pass once.
// Optional feature macro ALU_SEQ_EARLY_EXIT_EN: finish a shift as soon as the accumulator reaches zero.
module alu_shift_sequencer #(
    parameter int WIDTH      = 32,
    parameter int COUNT_BITS = 5
) (
    input  logic                  clock,
    input  logic                  reset_n,
    alu_shift_sequencer_if.slave  bus,
    output logic [3:0]            alu_op_o,
    output logic [WIDTH-1:0]      alu_reg2_o,
    output logic [WIDTH-1:0]      alu_reg3_o,
    output logic                  alu_carry_in_o,
    input  logic [WIDTH-1:0]      alu_result_i,
    input  logic                  alu_carry_i,
    input  logic                  alu_zero_i,
    input  logic                  alu_neg_i,
    input  logic                  alu_over_i
);
    // Encoding must match the alu's op input.
    typedef enum logic [3:0] {
        OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_AND, OP_OR, OP_XOR, OP_NOT,
        OP_LOGIC_LEFT, OP_LOGIC_RIGHT, OP_ARITH_LEFT, OP_ARITH_RIGHT
    } t_alu_op;
    typedef enum logic [1:0] {IDLE, RUN, FIN} t_state;

    t_state                state_q, state_d;
    t_alu_op               op_q, req_op;
    logic [WIDTH-1:0]      acc_q, b_q;
    logic [COUNT_BITS-1:0] cnt_q;
    logic                  cin_q, carry_q, zero_q, neg_q, over_q;
    logic                  req_shift, run_shift, run, early;

    function automatic logic is_shift(t_alu_op o);
        return o inside {OP_LOGIC_LEFT, OP_LOGIC_RIGHT, OP_ARITH_LEFT, OP_ARITH_RIGHT};
    endfunction

    assign req_op    = t_alu_op'(bus.op);
    assign req_shift = is_shift(req_op);
    assign run_shift = is_shift(op_q);
    assign run       = state_q == RUN;

`ifdef ALU_SEQ_EARLY_EXIT_EN
    // Once a shift has produced zero every further step yields zero, so stop now.
    assign early = run && run_shift && alu_result_i == '0 && cnt_q > COUNT_BITS'(1);
`else
    assign early = 1'b0;
`endif

    // Next state: zero-count shifts skip RUN; non-shift ops spend exactly one cycle in RUN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = (req_shift && bus.count == '0) ? FIN : RUN;
            RUN:     if (!run_shift || cnt_q == COUNT_BITS'(1) || early) state_d = FIN;
            default: state_d = IDLE;
        endcase
    end

    // ALU drive: the accumulator feeds reg2 while running; idle defaults otherwise.
    always_comb begin
        alu_op_o       = run ? op_q : OP_ADD;
        alu_reg2_o     = run ? acc_q : '0;
        alu_reg3_o     = (run && !run_shift) ? b_q : '0;
        alu_carry_in_o = run && cin_q;
    end

    assign bus.busy      = state_q != IDLE;
    assign bus.done      = state_q == FIN;
    assign bus.result    = acc_q;
    assign bus.carry_out = carry_q;
    assign bus.zero_out  = zero_q;
    assign bus.neg_out   = neg_q;
    assign bus.over_out  = over_q;

    // Latch the request on acceptance, then fold each ALU step back into the accumulator and flags.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            op_q    <= OP_ADD;
            acc_q   <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            cin_q   <= 1'b0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && bus.start) begin
                op_q    <= req_op;
                acc_q   <= bus.operand_a;
                b_q     <= bus.operand_b;
                cnt_q   <= bus.count;
                cin_q   <= bus.carry_in;
                carry_q <= bus.carry_in;
                zero_q  <= bus.operand_a == '0;
                neg_q   <= bus.operand_a[WIDTH-1];
                over_q  <= 1'b0;
            end else if (run) begin
                acc_q   <= alu_result_i;
                carry_q <= alu_carry_i && !early;
                zero_q  <= alu_zero_i;
                neg_q   <= alu_neg_i;
                over_q  <= run_shift ? (over_q | alu_over_i) : alu_over_i;
                cnt_q   <= cnt_q - COUNT_BITS'(1);
            end
        end
    end
endmodule
